// File: rtl/nabp_image_ram_writer.sv
// nabp_image_ram_writer
//   Downstream consumer of the NABP image-RAM readout. It kicks NABP, paces
//   the readout with ir_enable so that the capture FIFO can never overflow,
//   buffers each (address, value) pair, and writes the pairs into an image RAM
//   write port that may stall. Completion and the written-word count are
//   reported to the host.
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   hs_kick                 host start pulse (accepted only in IDLE)
//   hs_busy / hs_done       run in progress / one-cycle completion pulse
//   hs_word_count           words written in the current or last run
//   hs_overflow             sticky: a capture was attempted into a full FIFO
//   ir_kick / ir_kick_ack   readout request handshake with NABP
//   ir_enable               readout advance; word arrives one cycle later
//   ir_done                 NABP has presented its last word
//   ir_addr / ir_val        word presented by NABP
//   mem_we/addr/data/ready  image RAM write port with backpressure
module nabp_image_ram_writer #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 12,
  parameter int FIFO_DEPTH  = 4,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   hs_kick,
  output logic                   hs_busy,
  output logic                   hs_done,
  output logic [COUNT_WIDTH-1:0] hs_word_count,
  output logic                   hs_overflow,
  output logic                   ir_kick,
  output logic                   ir_enable,
  input  logic                   ir_kick_ack,
  input  logic                   ir_done,
  input  logic [ADDR_WIDTH-1:0]  ir_addr,
  input  logic [DATA_WIDTH-1:0]  ir_val,
  output logic                   mem_we,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0]  mem_data,
  input  logic                   mem_ready
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = ADDR_WIDTH + DATA_WIDTH;

  localparam logic [CNT_W-1:0]       DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W:0]         DEPTH_X   = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = {COUNT_WIDTH{1'b1}};

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_KICK   = 3'd1;
  localparam logic [2:0] ST_STREAM = 3'd2;
  localparam logic [2:0] ST_DRAIN  = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  logic [2:0]             state_q, state_d;
  logic                   enable_q;
  logic [ENTRY_W-1:0]     fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [COUNT_WIDTH-1:0] word_count_q, word_count_d;
  logic                   overflow_q;

  logic                   fifo_empty_s;
  logic                   fifo_full_s;
  logic                   pop_s;
  logic                   push_ok_s;
  logic                   overflow_set_s;
  logic [CNT_W:0]         occupancy_s;
  logic [ENTRY_W-1:0]     head_s;

  // FIFO status, push/pop qualification and readout pacing
  always_comb begin
    fifo_empty_s   = (count_q == {CNT_W{1'b0}});
    fifo_full_s    = (count_q == DEPTH_C);
    pop_s          = !fifo_empty_s && mem_ready;
    // capture is governed solely by enable_q; a full FIFO only accepts the
    // word if the head leaves in the same cycle
    push_ok_s      = enable_q && (!fifo_full_s || pop_s);
    overflow_set_s = enable_q && fifo_full_s && !pop_s;
    // the word requested last cycle is still in flight, so reserve its slot
    occupancy_s    = {1'b0, count_q} + {{CNT_W{1'b0}}, enable_q};
    ir_enable      = (state_q == ST_STREAM) && !ir_done && (occupancy_s < DEPTH_X);
    head_s         = fifo_mem_q[rd_ptr_q];
  end

  // Controller next-state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (hs_kick) state_d = ST_KICK;
        else         state_d = ST_IDLE;
      end
      ST_KICK: begin
        if (ir_kick_ack) state_d = ST_STREAM;
        else             state_d = ST_KICK;
      end
      ST_STREAM: begin
        if (ir_done) state_d = ST_DRAIN;
        else         state_d = ST_STREAM;
      end
      ST_DRAIN: begin
        // enable_q may still carry the final word into the first DRAIN cycle
        if (fifo_empty_s && !enable_q) state_d = ST_DONE;
        else                           state_d = ST_DRAIN;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FIFO occupancy next-state
  always_comb begin
    count_d = count_q;
    case ({push_ok_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Written-word counter: cleared on an accepted kick, saturating increment
  always_comb begin
    word_count_d = word_count_q;
    if ((state_q == ST_IDLE) && hs_kick) begin
      word_count_d = {COUNT_WIDTH{1'b0}};
    end else if (pop_s && (word_count_q != COUNT_MAX)) begin
      word_count_d = word_count_q + COUNT_WIDTH'(1);
    end else begin
      word_count_d = word_count_q;
    end
  end

  // Controller state, pacing history, counter and sticky overflow flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      enable_q     <= 1'b0;
      word_count_q <= {COUNT_WIDTH{1'b0}};
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      enable_q     <= ir_enable;
      word_count_q <= word_count_d;
      overflow_q   <= overflow_q | overflow_set_s;
    end
  end

  // Capture FIFO storage and pointers; pointers wrap naturally (power of two)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_q[i] <= {ENTRY_W{1'b0}};
      end
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        fifo_mem_q[wr_ptr_q] <= {ir_addr, ir_val};
        wr_ptr_q             <= wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_q <= wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_q <= rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

  assign hs_busy       = (state_q != ST_IDLE);
  assign hs_done       = (state_q == ST_DONE);
  assign hs_word_count = word_count_q;
  assign hs_overflow   = overflow_q;
  assign ir_kick       = (state_q == ST_KICK);
  assign mem_we        = !fifo_empty_s;
  assign mem_addr      = head_s[ENTRY_W-1:DATA_WIDTH];
  assign mem_data      = head_s[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_nabp_image_ram_writer.sv
// Self-checking bench for nabp_image_ram_writer. An NABP model presents a list
// of words whenever it is paced, a RAM model applies backpressure, and every
// write is compared in order against the presented list.
module tb_nabp_image_ram_writer;

  localparam int DW = 16;
  localparam int AW = 12;
  localparam int FD = 4;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          hs_kick;
  logic          hs_busy;
  logic          hs_done;
  logic [CW-1:0] hs_word_count;
  logic          hs_overflow;
  logic          ir_kick;
  logic          ir_enable;
  logic          ir_kick_ack;
  logic          ir_done;
  logic [AW-1:0] ir_addr;
  logic [DW-1:0] ir_val;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          mem_ready;

  int total = 0;
  int bad   = 0;

  logic [AW-1:0] word_a [$];
  logic [DW-1:0] word_d [$];

  always #5 clk = ~clk;

  nabp_image_ram_writer #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(FD), .COUNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .hs_kick(hs_kick), .hs_busy(hs_busy),
    .hs_done(hs_done), .hs_word_count(hs_word_count), .hs_overflow(hs_overflow),
    .ir_kick(ir_kick), .ir_enable(ir_enable), .ir_kick_ack(ir_kick_ack),
    .ir_done(ir_done), .ir_addr(ir_addr), .ir_val(ir_val), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic logic outs_zero();
    return !(|{hs_busy, hs_done, hs_word_count, hs_overflow, ir_kick, ir_enable,
               mem_we, mem_addr, mem_data});
  endfunction

  // One run. mode: 0 ready, 1 ten-cycle stall at stall_at, 2 random, 3 never ready.
  task automatic run(input int n, input int ack_dly, input int mode, input int stall_at,
                     input bit kick_again, input bit abort, input bit basic);
    int p = 0, w = 0, kick_seen = 0, done_pulses = 0, stream_cyc = 0;
    bit en_prev = 0, kick_prev = 0, ack_last = 0, stream_next = 0, in_stream = 0;
    bit stalled_prev = 0, finished = 0;
    logic [AW-1:0] pa = '0;
    logic [DW-1:0] pd = '0;
    word_a.delete();
    word_d.delete();
    for (int i = 0; i < n; i++) begin
      if (basic) begin
        word_a.push_back(AW'(i));
        word_d.push_back(DW'(i * 3));
      end else begin
        word_a.push_back(AW'($urandom));
        word_d.push_back(DW'($urandom));
      end
    end
    ir_done = 1'b0;
    for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
      @(negedge clk);
      if (abort && p >= 3) begin
        reset_n = 1'b0;
        #1;
        check("reset_outs_zero", 32'(outs_zero()), 32'd1);
        finished = 1;
      end else begin
        hs_kick = (cyc == 0) || (kick_again && cyc == 6);
        if (stream_next && !in_stream) begin
          in_stream  = 1;
          stream_cyc = cyc;
        end
        ir_kick_ack = kick_prev && (kick_seen >= ack_dly);
        stream_next = ir_kick_ack;
        if (in_stream && n == 0) ir_done = 1'b1;
        if (en_prev) begin
          if (p < n) begin
            ir_addr = word_a[p];
            ir_val  = word_d[p];
            p++;
            if (p == n) ir_done = 1'b1;
          end else begin
            check("extra_enable", 32'(en_prev), 32'd0);
          end
        end else begin
          ir_addr = AW'($urandom);
          ir_val  = DW'($urandom);
        end
        case (mode)
          0:       mem_ready = 1'b1;
          1:       mem_ready = !(cyc >= stall_at && cyc < stall_at + 10);
          2:       mem_ready = ($urandom_range(0, 2) != 0);
          default: mem_ready = 1'b0;
        endcase
        #1;
        if (n == 0) check("zero_we", 32'(mem_we), 32'd0);
        if (ir_kick) check("kick_en", 32'(ir_enable), 32'd0);
        if (kick_prev && !ack_last) check("kick_hold", 32'(ir_kick), 32'd1);
        if (cyc >= 1 && done_pulses == 0) check("busy", 32'(hs_busy), 32'd1);
        if (stalled_prev) begin
          check("stall_addr", 32'(mem_addr), 32'(pa));
          check("stall_data", 32'(mem_data), 32'(pd));
        end
        check("occupancy_le", 32'((p - w) <= FD), 32'd1);
        if (mem_we && mem_ready) begin
          if (w < n) begin
            check("wr_addr", 32'(mem_addr), 32'(word_a[w]));
            check("wr_data", 32'(mem_data), 32'(word_d[w]));
          end else begin
            check("extra_write", 32'(mem_we), 32'd0);
          end
          w++;
        end
        stalled_prev = mem_we && !mem_ready;
        pa = mem_addr;
        pd = mem_data;
        if (hs_done) begin
          done_pulses++;
          check("done_written", 32'(w), 32'(n));
          check("done_count", 32'(hs_word_count), 32'(n));
          check("done_ovf", 32'(hs_overflow), 32'd0);
          if (n == 0) check("zero_latency", 32'(cyc - stream_cyc), 32'd2);
        end else if (done_pulses > 0) begin
          check("post_done_busy", 32'(hs_busy), 32'd0);
          finished = 1;
        end
        if (ir_kick) kick_seen++;
        kick_prev = ir_kick;
        ack_last  = ir_kick_ack;
        en_prev   = ir_enable;
      end
    end
    if (!finished) check("timeout", 32'd0, 32'd1);
    hs_kick     = 1'b0;
    ir_kick_ack = 1'b0;
    ir_done     = 1'b0;
    mem_ready   = 1'b1;
    if (abort) begin
      check("abort_no_done", 32'(done_pulses), 32'd0);
      repeat (2) @(negedge clk);
      #1;
      check("reset_held_zero", 32'(outs_zero()), 32'd1);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      check("release_zero", 32'(outs_zero()), 32'd1);
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        #1;
        check("abort_idle", 32'({hs_done, hs_busy, mem_we}), 32'd0);
      end
    end else begin
      check("done_pulses", 32'(done_pulses), 32'd1);
      check("all_written", 32'(w), 32'(n));
    end
  endtask

  // Fill the FIFO under a stalled RAM, then force an unpaced capture.
  task automatic overflow_test();
    int got_done = 0;
    @(negedge clk);
    hs_kick     = 1'b1;
    ir_kick_ack = 1'b1;
    mem_ready   = 1'b0;
    @(negedge clk);
    hs_kick = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      ir_kick_ack = 1'b0;
      ir_addr     = AW'($urandom);
      ir_val      = DW'($urandom);
    end
    #1;
    check("ovf_full_we", 32'(mem_we), 32'd1);
    check("ovf_full_en", 32'(ir_enable), 32'd0);
    check("ovf_clear_before", 32'(hs_overflow), 32'd0);
    force dut.enable_q = 1'b1;
    @(posedge clk);
    @(negedge clk);
    release dut.enable_q;
    #1;
    check("ovf_set", 32'(hs_overflow), 32'd1);
    @(negedge clk);
    mem_ready = 1'b1;
    ir_done   = 1'b1;
    for (int k = 0; k < 100 && got_done == 0; k++) begin
      @(negedge clk);
      #1;
      check("ovf_sticky", 32'(hs_overflow), 32'd1);
      if (hs_done) got_done = 1;
    end
    check("ovf_run_done", 32'(got_done), 32'd1);
    ir_done = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("ovf_reset_clear", 32'(hs_overflow), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n     = 1'b0;
    hs_kick     = 1'b0;
    ir_kick_ack = 1'b0;
    ir_done     = 1'b0;
    ir_addr     = '0;
    ir_val      = '0;
    mem_ready   = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("init_reset_zero", 32'(outs_zero()), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("init_release_zero", 32'(outs_zero()), 32'd1);

    run(16, 3, 0, 0, 1'b0, 1'b0, 1'b1);   // basic
    run(16, 3, 1, 12, 1'b0, 1'b0, 1'b1);  // backpressure
    run(16, 20, 0, 0, 1'b1, 1'b0, 1'b1);  // long kick wait, second kick ignored
    run(0, 2, 0, 0, 1'b0, 1'b0, 1'b1);    // zero-length
    run(16, 1, 3, 0, 1'b0, 1'b1, 1'b1);   // reset with words buffered
    run(16, 3, 0, 0, 1'b0, 1'b0, 1'b1);   // fresh run after abort
    overflow_test();
    for (int r = 0; r < 6; r++) begin
      run($urandom_range(1, 20), $urandom_range(0, 5), 2, 0, 1'b0, 1'b0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
